// File: rtl/enemy_bank_pkg.sv
// Shared constants and FSM encoding for the dodge-game enemy controller.
package game_pkg;

    localparam int unsigned SCREEN_W     = 160;
    localparam int unsigned SCREEN_H     = 120;
    localparam int unsigned PLAYER_WIDTH = 3;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned W_W   = 3;
    localparam int unsigned D_W   = 3;
    localparam int unsigned IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STEP,
        ST_CHECK,
        ST_DRAW
    } state_t;

endpackage

// File: rtl/enemy_bank_if.sv
// Snapshot stream between the enemy bank and the VGA drawer.
interface enemy_bank_if;
    import game_pkg::*;

    logic             draw_req;
    logic             obj_valid;
    logic [IDX_W-1:0] obj_idx;
    logic [X_W-1:0]   obj_x;
    logic [Y_W-1:0]   obj_y;
    logic [W_W-1:0]   obj_width;
    logic             frame_done;

    modport master (
        output draw_req,
        input  obj_valid, obj_idx, obj_x, obj_y, obj_width, frame_done
    );

    modport slave (
        input  draw_req,
        output obj_valid, obj_idx, obj_x, obj_y, obj_width, frame_done
    );

endinterface

// File: rtl/enemy_bank_axis_step.sv
// Single-axis bounce step: next position and direction for one enemy on one axis.
module axis_step #(
    parameter int unsigned EXTENT = 160,
    parameter int unsigned CW     = 8
) (
    input  logic [CW-1:0] pos,
    input  logic [2:0]    size,
    input  logic [2:0]    step,
    input  logic          neg,
    output logic [CW-1:0] next_pos,
    output logic          next_neg
);

    logic [CW:0] pos_w;
    logic [CW:0] size_w;
    logic [CW:0] step_w;
    logic [CW:0] far_edge;

    always_comb begin
        pos_w    = {1'b0, pos};
        size_w   = (CW+1)'(size);
        step_w   = (CW+1)'(step);
        far_edge = pos_w + size_w + step_w;
        next_pos = pos;
        next_neg = neg;
        // A zero step must neither move nor flip, even when sitting on an edge.
        if (step != '0) begin
            if (neg) begin
                if (pos_w <= step_w) begin
                    next_pos = '0;
                    next_neg = 1'b0;
                end else begin
                    next_pos = pos - CW'(step);
                end
            end else begin
                if (far_edge >= (CW+1)'(EXTENT)) begin
                    next_pos = CW'((CW+1)'(EXTENT) - size_w);
                    next_neg = 1'b1;
                end else begin
                    next_pos = pos + CW'(step);
                end
            end
        end
    end

endmodule

// File: rtl/enemy_bank.sv
// Multi-enemy controller: time-multiplexed movement, per-slot collision latch,
// and one-slot-per-cycle snapshot streaming to the drawer.
module enemy_bank #(
    parameter int unsigned N_ENEMIES    = 4,
    parameter int unsigned SCREEN_W     = game_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H     = game_pkg::SCREEN_H,
    parameter int unsigned PLAYER_WIDTH = game_pkg::PLAYER_WIDTH,
    parameter int unsigned RATE_DIV     = 1000000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_level,
    input  logic                     play,
    input  logic [8*N_ENEMIES-1:0]   start_x,
    input  logic [7*N_ENEMIES-1:0]   start_y,
    input  logic [3*N_ENEMIES-1:0]   d_x,
    input  logic [3*N_ENEMIES-1:0]   d_y,
    input  logic [3*N_ENEMIES-1:0]   width,
    input  logic [N_ENEMIES-1:0]     leftwards,
    input  logic [N_ENEMIES-1:0]     upwards,
    input  logic [7:0]               player_x,
    input  logic [6:0]               player_y,
    enemy_bank_if.slave              drw,
    output logic                     move,
    output logic [N_ENEMIES-1:0]     hit_mask,
    output logic                     player_hit,
    output logic                     busy
);
    import game_pkg::*;

    localparam int unsigned IW    = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;
    localparam int unsigned CNT_W = $clog2(RATE_DIV);
    localparam logic [IW-1:0]    LAST    = IW'(N_ENEMIES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);

    state_t        state, state_next;
    logic [IW-1:0] idx, idx_next;
    logic          last;
    logic          step_en, check_en;

    logic [X_W-1:0] pos_x  [N_ENEMIES];
    logic [Y_W-1:0] pos_y  [N_ENEMIES];
    logic [W_W-1:0] size   [N_ENEMIES];
    logic [D_W-1:0] step_x [N_ENEMIES];
    logic [D_W-1:0] step_y [N_ENEMIES];
    logic           dir_l  [N_ENEMIES];
    logic           dir_u  [N_ENEMIES];

    logic [CNT_W-1:0] cnt;
    logic             tick_pend;

    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           nl, nu;
    logic           hit_now;

    assign last = (idx == LAST);

    axis_step #(.EXTENT(SCREEN_W), .CW(X_W)) u_step_x (
        .pos(pos_x[idx]), .size(size[idx]), .step(step_x[idx]), .neg(dir_l[idx]),
        .next_pos(nx), .next_neg(nl)
    );

    axis_step #(.EXTENT(SCREEN_H), .CW(Y_W)) u_step_y (
        .pos(pos_y[idx]), .size(size[idx]), .step(step_y[idx]), .neg(dir_u[idx]),
        .next_pos(ny), .next_neg(nu)
    );

    always_comb begin
        hit_now = (size[idx] != '0)
            && ({1'b0, player_x} < {1'b0, pos_x[idx]} + 9'(size[idx]))
            && ({1'b0, pos_x[idx]} < {1'b0, player_x} + 9'(PLAYER_WIDTH))
            && ({1'b0, player_y} < {1'b0, pos_y[idx]} + 8'(size[idx]))
            && ({1'b0, pos_y[idx]} < {1'b0, player_y} + 8'(PLAYER_WIDTH));
    end

    always_ff @(posedge clk) begin : state_reg
        if (!resetn) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_comb begin : next_state
        state_next = state;
        idx_next   = '0;
        if (load_level) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (tick_pend)         state_next = ST_STEP;
                    else if (drw.draw_req) state_next = ST_DRAW;
                end
                ST_STEP: begin
                    if (last) state_next = ST_CHECK;
                    else      idx_next   = idx + 1'b1;
                end
                ST_CHECK, ST_DRAW: begin
                    if (last) state_next = ST_IDLE;
                    else      idx_next   = idx + 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        busy       = (state != ST_IDLE);
        step_en    = (state == ST_STEP);
        check_en   = (state == ST_CHECK);
        player_hit = |hit_mask;
    end

    always_ff @(posedge clk) begin : tick_gen
        if (!resetn || load_level) begin
            cnt       <= '0;
            tick_pend <= 1'b0;
        end else begin
            if (play) cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            // A fresh wrap wins over the clear so a tick landing on the IDLE handoff is kept.
            if (play && cnt == CNT_MAX)            tick_pend <= 1'b1;
            else if (state == ST_IDLE && tick_pend) tick_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin : slot_regs
        if (!resetn) begin
            for (int unsigned i = 0; i < N_ENEMIES; i++) begin
                pos_x[i]  <= '0;
                pos_y[i]  <= '0;
                size[i]   <= '0;
                step_x[i] <= '0;
                step_y[i] <= '0;
                dir_l[i]  <= 1'b0;
                dir_u[i]  <= 1'b0;
            end
        end else if (load_level) begin
            for (int unsigned i = 0; i < N_ENEMIES; i++) begin
                pos_x[i]  <= start_x[X_W*i +: X_W];
                pos_y[i]  <= start_y[Y_W*i +: Y_W];
                size[i]   <= width[W_W*i +: W_W];
                step_x[i] <= d_x[D_W*i +: D_W];
                step_y[i] <= d_y[D_W*i +: D_W];
                dir_l[i]  <= leftwards[i];
                dir_u[i]  <= upwards[i];
            end
        end else if (step_en && size[idx] != '0) begin
            pos_x[idx] <= nx;
            pos_y[idx] <= ny;
            dir_l[idx] <= nl;
            dir_u[idx] <= nu;
        end
    end

    always_ff @(posedge clk) begin : hit_regs
        if (!resetn || load_level) begin
            hit_mask <= '0;
            move     <= 1'b0;
        end else begin
            move <= check_en && last;
            if (check_en && hit_now) hit_mask[idx] <= 1'b1;
        end
    end

    // Stream registers load from the next-state slot so data lines up with DRAW cycles.
    always_ff @(posedge clk) begin : obj_regs
        if (!resetn || state_next != ST_DRAW) begin
            drw.obj_valid  <= 1'b0;
            drw.obj_idx    <= '0;
            drw.obj_x      <= '0;
            drw.obj_y      <= '0;
            drw.obj_width  <= '0;
            drw.frame_done <= 1'b0;
        end else begin
            drw.obj_valid  <= (size[idx_next] != '0);
            drw.obj_idx    <= IDX_W'(idx_next);
            drw.obj_x      <= pos_x[idx_next];
            drw.obj_y      <= pos_y[idx_next];
            drw.obj_width  <= size[idx_next];
            drw.frame_done <= (idx_next == LAST);
        end
    end

endmodule

// File: tb/tb_enemy_bank.sv
// Table-driven bench for enemy_bank (N=2, RATE_DIV=8) with a queue scoreboard on the draw stream.
module tb_enemy_bank;
    import game_pkg::*;

    localparam int N  = 2;
    localparam int RD = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, load_level, play;
    logic [15:0] start_x;
    logic [13:0] start_y;
    logic [5:0]  d_x, d_y, width;
    logic [1:0]  leftwards, upwards;
    logic [7:0]  player_x;
    logic [6:0]  player_y;
    logic        move, player_hit, busy;
    logic [1:0]  hit_mask;

    enemy_bank_if bus();

    enemy_bank #(.N_ENEMIES(N), .RATE_DIV(RD)) dut (
        .clk(clk), .resetn(resetn), .load_level(load_level), .play(play),
        .start_x(start_x), .start_y(start_y), .d_x(d_x), .d_y(d_y), .width(width),
        .leftwards(leftwards), .upwards(upwards),
        .player_x(player_x), .player_y(player_y),
        .drw(bus),
        .move(move), .hit_mask(hit_mask), .player_hit(player_hit), .busy(busy)
    );

    typedef struct packed {
        logic [7:0] x; logic [6:0] y; logic [2:0] w, dx, dy; logic l, u;
    } slot_cfg_t;

    typedef struct packed {
        slot_cfg_t  s0, s1;
        logic [7:0] px; logic [6:0] py;
        logic [3:0] ticks;
        logic [7:0] ex0; logic [6:0] ey0;
        logic [7:0] ex1; logic [6:0] ey1;
        logic [1:0] ehit;
    } vec_t;

    typedef struct packed {
        logic v; logic [3:0] idx; logic [7:0] x; logic [6:0] y; logic [2:0] w; logic fd;
    } obj_t;

    obj_t sb[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;

    function automatic slot_cfg_t mk_slot(input int x, y, w, dx, dy, l, u);
        slot_cfg_t s;
        s.x = 8'(x); s.y = 7'(y); s.w = 3'(w); s.dx = 3'(dx); s.dy = 3'(dy);
        s.l = (l != 0); s.u = (u != 0);
        return s;
    endfunction

    function automatic vec_t mk_vec(input slot_cfg_t a, b, input int px, py, t,
                                    ex0, ey0, ex1, ey1, eh);
        vec_t v;
        v.s0 = a; v.s1 = b; v.px = 8'(px); v.py = 7'(py); v.ticks = 4'(t);
        v.ex0 = 8'(ex0); v.ey0 = 7'(ey0); v.ex1 = 8'(ex1); v.ey1 = 7'(ey1);
        v.ehit = 2'(eh);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic v, input int idx, input logic [7:0] x,
                            input logic [6:0] y, input logic [2:0] w);
        obj_t e;
        e.v = v; e.idx = 4'(idx); e.x = x; e.y = y; e.w = w; e.fd = (idx == N-1);
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string name);
        obj_t e, a;
        a = {bus.obj_valid, bus.obj_idx, bus.obj_x, bus.obj_y, bus.obj_width, bus.frame_done};
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            e = sb.pop_front();
            check(name, 32'(a), 32'(e));
        end
    endtask

    task automatic draw_stream(input string tag);
        bus.draw_req = 1'b1;
        @(negedge clk);
        bus.draw_req = 1'b0;
        for (int k = 0; k < N; k++) begin
            pop_cmp($sformatf("%s_slot%0d", tag, k));
            if (k < N-1) @(negedge clk);
        end
        @(negedge clk);
        check({tag, "_after"}, {29'd0, bus.obj_valid, bus.frame_done, busy}, 32'd0);
    endtask

    task automatic load_cfg(input slot_cfg_t a, b, input logic [7:0] px, input logic [6:0] py);
        start_x   = {b.x, a.x};   start_y  = {b.y, a.y};
        width     = {b.w, a.w};   d_x      = {b.dx, a.dx};  d_y = {b.dy, a.dy};
        leftwards = {b.l, a.l};   upwards  = {b.u, a.u};
        player_x  = px;           player_y = py;
        load_level = 1'b1;
        @(negedge clk);
        load_level = 1'b0;
    endtask

    task automatic wait_busy(input string tag, output bit ok);
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = busy;
        if (!ok) check({tag, "_tick_timeout"}, 32'(busy), 32'(1));
    endtask

    task automatic do_tick(input string tag);
        bit ok;
        play = 1'b1;
        wait_busy(tag, ok);
        play = 1'b0;
        if (ok) begin
            repeat (4) @(negedge clk);
            check({tag, "_move"}, {30'd0, move, busy}, 32'b10);
            @(negedge clk);
            check({tag, "_move_end"}, 32'(move), 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        slot_cfg_t off, a, b;
        bit ok;
        int move_seen;

        off = mk_slot(0, 0, 0, 0, 0, 0, 0);
        vecs[0] = mk_vec(mk_slot(5, 10, 2, 3, 0, 1, 0), mk_slot(50, 20, 0, 3, 3, 0, 0),
                         50, 20, 1, 2, 10, 50, 20, 0);
        vecs[1] = mk_vec(mk_slot(5, 10, 2, 3, 0, 1, 0), mk_slot(50, 20, 0, 3, 3, 0, 0),
                         50, 20, 2, 0, 10, 50, 20, 0);
        vecs[2] = mk_vec(mk_slot(5, 10, 2, 3, 0, 1, 0), mk_slot(50, 20, 0, 3, 3, 0, 0),
                         50, 20, 3, 3, 10, 50, 20, 0);
        vecs[3] = mk_vec(mk_slot(156, 50, 3, 2, 0, 0, 0), off, 0, 0, 1, 157, 50, 0, 0, 0);
        vecs[4] = mk_vec(mk_slot(156, 50, 3, 2, 0, 0, 0), off, 0, 0, 2, 155, 50, 0, 0, 0);
        vecs[5] = mk_vec(off, mk_slot(80, 113, 3, 0, 0, 0, 0), 81, 115, 1, 0, 0, 80, 113, 2);
        vecs[6] = mk_vec(mk_slot(100, 3, 1, 7, 3, 1, 1), mk_slot(10, 115, 4, 1, 3, 0, 0),
                         84, 1, 2, 86, 3, 12, 113, 1);
        vecs[7] = mk_vec(mk_slot(0, 0, 7, 7, 7, 0, 0), mk_slot(152, 112, 7, 1, 1, 0, 0),
                         150, 110, 2, 14, 14, 152, 112, 2);

        resetn = 1'b0; load_level = 1'b0; play = 1'b0; bus.draw_req = 1'b0;
        start_x = '0; start_y = '0; d_x = '0; d_y = '0; width = '0;
        leftwards = '0; upwards = '0; player_x = '0; player_y = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", {3'd0, bus.obj_valid, bus.obj_idx, bus.obj_x, bus.obj_y,
              bus.obj_width, bus.frame_done, move, hit_mask, player_hit, busy}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        push_exp(1'b0, 0, 8'd0, 7'd0, 3'd0);
        push_exp(1'b0, 1, 8'd0, 7'd0, 3'd0);
        draw_stream("rst");

        for (int i = 0; i < 8; i++) begin
            load_cfg(vecs[i].s0, vecs[i].s1, vecs[i].px, vecs[i].py);
            for (int t = 0; t < int'(vecs[i].ticks); t++) do_tick($sformatf("v%0d_t%0d", i, t));
            check($sformatf("v%0d_hit", i), {29'd0, hit_mask, player_hit},
                  {29'd0, vecs[i].ehit, |vecs[i].ehit});
            push_exp(vecs[i].s0.w != 0, 0, vecs[i].ex0, vecs[i].ey0, vecs[i].s0.w);
            push_exp(vecs[i].s1.w != 0, 1, vecs[i].ex1, vecs[i].ey1, vecs[i].s1.w);
            draw_stream($sformatf("v%0d", i));
        end

        // Sticky collision flags survive the enemy moving away; reload clears them.
        load_cfg(off, mk_slot(80, 113, 3, 5, 0, 0, 0), 8'd84, 7'd115);
        do_tick("sticky_t0");
        check("sticky_hit1", {29'd0, hit_mask, player_hit}, 32'b101);
        do_tick("sticky_t1");
        check("sticky_hit2", {29'd0, hit_mask, player_hit}, 32'b101);
        push_exp(1'b0, 0, 8'd0, 7'd0, 3'd0);
        push_exp(1'b1, 1, 8'd90, 7'd113, 3'd3);
        draw_stream("sticky");
        load_level = 1'b1;
        @(negedge clk);
        load_level = 1'b0;
        check("sticky_clear", {29'd0, hit_mask, player_hit}, 32'd0);

        // Tick and draw request in the same IDLE cycle: the pass runs first.
        load_cfg(mk_slot(5, 10, 2, 3, 0, 1, 0), off, 8'd150, 7'd0);
        play = 1'b1;
        repeat (8) @(negedge clk);
        check("both_idle", 32'(busy), 32'(0));
        play = 1'b0;
        bus.draw_req = 1'b1;
        push_exp(1'b1, 0, 8'd2, 7'd10, 3'd2);
        push_exp(1'b0, 1, 8'd0, 7'd0, 3'd0);
        @(negedge clk);
        check("both_step0", {29'd0, busy, bus.obj_valid, bus.frame_done}, 32'b100);
        repeat (3) @(negedge clk);
        check("both_check1", {29'd0, busy, bus.obj_valid, bus.frame_done}, 32'b100);
        @(negedge clk);
        check("both_move", {30'd0, move, busy}, 32'b10);
        @(negedge clk);
        bus.draw_req = 1'b0;
        pop_cmp("both_slot0");
        @(negedge clk);
        pop_cmp("both_slot1");
        @(negedge clk);
        check("both_after", {30'd0, busy, bus.obj_valid}, 32'd0);

        // load_level mid-STEP aborts the pass and restores the start positions.
        load_cfg(mk_slot(5, 10, 2, 3, 0, 1, 0), mk_slot(80, 113, 3, 5, 0, 0, 0), 8'd0, 7'd100);
        play = 1'b1;
        wait_busy("abort", ok);
        play = 1'b0;
        a = mk_slot(40, 30, 2, 1, 1, 0, 0);
        b = mk_slot(120, 60, 5, 2, 2, 1, 1);
        load_cfg(a, b, 8'd0, 7'd100);
        check("abort_idle", 32'(busy), 32'(0));
        move_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (move) move_seen++;
        end
        check("abort_no_move", 32'(move_seen), 32'(0));
        push_exp(1'b1, 0, 8'd40, 7'd30, 3'd2);
        push_exp(1'b1, 1, 8'd120, 7'd60, 3'd5);
        draw_stream("abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
